// File: rtl/aq_reduce_ctrl.sv
// Frame sequencer in front of the aq_reduce scaling core: shadows the frame geometry,
// issues the core frame sync, gates the upstream pixel stream and tracks drain/completion.
module aq_reduce_ctrl #(
    parameter int DRAIN_TIMEOUT = 64,
    parameter int CNT_W         = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [15:0]      CFG_ORG_X,
    input  logic [15:0]      CFG_ORG_Y,
    input  logic [15:0]      CFG_CNV_X,
    input  logic [15:0]      CFG_CNV_Y,
    input  logic             CFG_START,
    input  logic             CFG_ABORT,
    input  logic             S_VALID,
    input  logic [31:0]      S_DATA,
    output logic             S_READY,
    output logic [15:0]      ORG_X,
    output logic [15:0]      ORG_Y,
    output logic [15:0]      CNV_X,
    output logic [15:0]      CNV_Y,
    output logic             DIN_WE,
    output logic             DIN_FSYNC,
    output logic [31:0]      DIN,
    input  logic             DOUT_OE,
    input  logic             DOUT_LAST,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [CNT_W-1:0] OUT_CNT
);

    // state    | meaning
    // IDLE     | waiting for a frame start request
    // SYNC     | geometry latched; frame sync is issued on leaving this state
    // RUN      | accepting upstream pixels until the input count is met
    // DRAIN    | input complete, waiting for the core to deliver all outputs
    // FIN      | one-cycle completion, DONE pulses
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);

    logic [2:0]       state_q, state_d;
    logic [15:0]      org_x_q, org_x_d, org_y_q, org_y_d;
    logic [15:0]      cnv_x_q, cnv_x_d, cnv_y_q, cnv_y_d;
    logic [CNT_W-1:0] exp_in_q, exp_in_d, exp_out_q, exp_out_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             s_ready_q, s_ready_d;
    logic             din_we_q, din_we_d;
    logic             fsync_q, fsync_d;
    logic [31:0]      din_q, din_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             cfg_ok;
    logic             hs;
    logic             counting;
    logic [31:0]      prod_in, prod_out;

    always_comb begin
        state_d   = state_q;
        org_x_d   = org_x_q;
        org_y_d   = org_y_q;
        cnv_x_d   = cnv_x_q;
        cnv_y_d   = cnv_y_q;
        exp_in_d  = exp_in_q;
        exp_out_d = exp_out_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        timer_d   = '0;
        din_d     = din_q;
        din_we_d  = 1'b0;
        fsync_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;

        cfg_ok = (CFG_ORG_X != 16'd0) && (CFG_ORG_Y != 16'd0) &&
                 (CFG_CNV_X != 16'd0) && (CFG_CNV_Y != 16'd0) &&
                 (CFG_CNV_X <= CFG_ORG_X) && (CFG_CNV_Y <= CFG_ORG_Y);
        prod_in  = CFG_ORG_X * CFG_ORG_Y;
        prod_out = CFG_CNV_X * CFG_CNV_Y;
        hs       = S_VALID & s_ready_q;
        counting = (state_q == ST_SYNC) || (state_q == ST_RUN) || (state_q == ST_DRAIN);

        if (counting && DOUT_OE && (out_cnt_q != '1))
            out_cnt_d = out_cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (CFG_START) begin
                    if (cfg_ok) begin
                        org_x_d   = CFG_ORG_X;
                        org_y_d   = CFG_ORG_Y;
                        cnv_x_d   = CFG_CNV_X;
                        cnv_y_d   = CFG_CNV_Y;
                        exp_in_d  = CNT_W'(prod_in);
                        exp_out_d = CNT_W'(prod_out);
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        err_d     = 1'b0;
                        state_d   = ST_SYNC;
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                if (CFG_ABORT) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    fsync_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (CFG_ABORT) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else if (hs) begin
                    din_we_d = 1'b1;
                    din_d    = S_DATA;
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if (in_cnt_d == exp_in_q)
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (CFG_ABORT) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else if (DOUT_OE && DOUT_LAST) begin
                    err_d   = (out_cnt_d != exp_out_q);
                    state_d = ST_FIN;
                end else if (out_cnt_d == exp_out_q) begin
                    state_d = ST_FIN;
                end else if (!DOUT_OE) begin
                    // The timer would reach DRAIN_TIMEOUT on this edge.
                    if (timer_q == TMR_W'(DRAIN_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        s_ready_d = (state_d == ST_RUN);
        busy_d    = (state_d == ST_SYNC) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
        if (state_d == ST_FIN)
            done_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            org_x_q   <= '0;
            org_y_q   <= '0;
            cnv_x_q   <= '0;
            cnv_y_q   <= '0;
            exp_in_q  <= '0;
            exp_out_q <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            timer_q   <= '0;
            s_ready_q <= 1'b0;
            din_we_q  <= 1'b0;
            fsync_q   <= 1'b0;
            din_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            org_x_q   <= org_x_d;
            org_y_q   <= org_y_d;
            cnv_x_q   <= cnv_x_d;
            cnv_y_q   <= cnv_y_d;
            exp_in_q  <= exp_in_d;
            exp_out_q <= exp_out_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            timer_q   <= timer_d;
            s_ready_q <= s_ready_d;
            din_we_q  <= din_we_d;
            fsync_q   <= fsync_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign S_READY   = s_ready_q;
    assign ORG_X     = org_x_q;
    assign ORG_Y     = org_y_q;
    assign CNV_X     = cnv_x_q;
    assign CNV_Y     = cnv_y_q;
    assign DIN_WE    = din_we_q;
    assign DIN_FSYNC = fsync_q;
    assign DIN       = din_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign OUT_CNT   = out_cnt_q;

endmodule

// File: tb/tb_aq_reduce_ctrl.sv
// Directed bench for aq_reduce_ctrl: frame flow, backpressure, bad config,
// drain timeout, abort, start-while-busy and mid-frame reset.
module tb_aq_reduce_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] CFG_ORG_X, CFG_ORG_Y, CFG_CNV_X, CFG_CNV_Y;
    logic        CFG_START, CFG_ABORT;
    logic        S_VALID;
    logic [31:0] S_DATA;
    logic        S_READY;
    logic [15:0] ORG_X, ORG_Y, CNV_X, CNV_Y;
    logic        DIN_WE, DIN_FSYNC;
    logic [31:0] DIN;
    logic        DOUT_OE, DOUT_LAST;
    logic        BUSY, DONE, ERR;
    logic [31:0] OUT_CNT;

    int vectors    = 0;
    int miscompares = 0;

    aq_reduce_ctrl #(.DRAIN_TIMEOUT(64), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .CFG_ORG_X(CFG_ORG_X), .CFG_ORG_Y(CFG_ORG_Y),
        .CFG_CNV_X(CFG_CNV_X), .CFG_CNV_Y(CFG_CNV_Y),
        .CFG_START(CFG_START), .CFG_ABORT(CFG_ABORT),
        .S_VALID(S_VALID), .S_DATA(S_DATA), .S_READY(S_READY),
        .ORG_X(ORG_X), .ORG_Y(ORG_Y), .CNV_X(CNV_X), .CNV_Y(CNV_Y),
        .DIN_WE(DIN_WE), .DIN_FSYNC(DIN_FSYNC), .DIN(DIN),
        .DOUT_OE(DOUT_OE), .DOUT_LAST(DOUT_LAST),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .OUT_CNT(OUT_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] pix(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    task automatic start_cfg(input logic [15:0] ox, input logic [15:0] oy,
                             input logic [15:0] cx, input logic [15:0] cy);
        CFG_ORG_X = ox; CFG_ORG_Y = oy; CFG_CNV_X = cx; CFG_CNV_Y = cy;
        CFG_START = 1'b1;
        tick();
        CFG_START = 1'b0;
    endtask

    task automatic feed(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            chk("s_ready_run", S_READY, 1'b1);
            S_VALID = 1'b1;
            S_DATA  = pix(base + i);
            tick();
            chk("din_we_beat", DIN_WE, 1'b1);
            chk("din_beat", DIN, pix(base + i));
        end
        S_VALID = 1'b0;
    endtask

    task automatic core_out(input int n, input logic last_on_final);
        for (int i = 0; i < n; i++) begin
            DOUT_OE   = 1'b1;
            DOUT_LAST = last_on_final && (i == n - 1);
            tick();
            DOUT_OE   = 1'b0;
            DOUT_LAST = 1'b0;
            if (i != n - 1) tick();
        end
    endtask

    initial begin
        logic [63:0] vpat;
        logic [31:0] last_din;
        logic        v;
        int          beats;
        int          n;

        RST = 1'b1; CFG_START = 1'b0; CFG_ABORT = 1'b0;
        CFG_ORG_X = '0; CFG_ORG_Y = '0; CFG_CNV_X = '0; CFG_CNV_Y = '0;
        S_VALID = 1'b0; S_DATA = '0; DOUT_OE = 1'b0; DOUT_LAST = 1'b0;
        vpat = 64'hB4E2_91C7_3A5D_6F08;

        // reset state
        tick(); tick();
        RST = 1'b0;
        tick();
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_err", ERR, 1'b0);
        chk("rst_ready", S_READY, 1'b0);
        chk("rst_fsync", DIN_FSYNC, 1'b0);
        chk("rst_we", DIN_WE, 1'b0);
        chk("rst_din", DIN, 32'h0);
        chk("rst_orgx", ORG_X, 16'h0);
        chk("rst_outcnt", OUT_CNT, 32'h0);

        // basic 4x4 -> 2x2 frame
        start_cfg(16'd4, 16'd4, 16'd2, 16'd2);
        chk("sync_busy", BUSY, 1'b1);
        chk("sync_ready", S_READY, 1'b0);
        chk("sync_fsync", DIN_FSYNC, 1'b0);
        chk("shadow_orgx", ORG_X, 16'd4);
        chk("shadow_cnvy", CNV_Y, 16'd2);
        tick();
        chk("fsync_hi", DIN_FSYNC, 1'b1);
        chk("fsync_we", DIN_WE, 1'b0);
        chk("run_ready", S_READY, 1'b1);
        tick();
        chk("fsync_once", DIN_FSYNC, 1'b0);
        feed(16, 0);
        chk("ready_after_last", S_READY, 1'b0);
        S_VALID = 1'b1;
        tick();
        chk("no_17th_beat", DIN_WE, 1'b0);
        S_VALID = 1'b0;
        core_out(4, 1'b1);
        chk("basic_done", DONE, 1'b1);
        chk("basic_err", ERR, 1'b0);
        chk("basic_outcnt", OUT_CNT, 32'd4);
        chk("basic_busy_fin", BUSY, 1'b0);
        tick();
        chk("basic_done_once", DONE, 1'b0);
        last_din = pix(15);

        // backpressure with an irregular valid pattern
        start_cfg(16'd4, 16'd4, 16'd2, 16'd2);
        tick();
        beats = 0;
        for (int cyc = 0; cyc < 200 && beats < 16; cyc++) begin
            v = vpat[cyc % 64];
            S_VALID = v;
            S_DATA  = pix(100 + beats);
            chk("bp_ready", S_READY, 1'b1);
            tick();
            chk("bp_we", DIN_WE, v);
            if (v) begin
                last_din = pix(100 + beats);
                beats++;
            end
            chk("bp_din", DIN, last_din);
        end
        chk("bp_beats", beats, 16);
        chk("bp_ready_after", S_READY, 1'b0);
        S_VALID = 1'b1;
        tick();
        chk("bp_no_17th", DIN_WE, 1'b0);
        S_VALID = 1'b0;
        core_out(4, 1'b1);
        chk("bp_done", DONE, 1'b1);
        chk("bp_err", ERR, 1'b0);
        chk("bp_outcnt", OUT_CNT, 32'd4);

        // DOUT_OE in IDLE is not counted
        tick();
        DOUT_OE = 1'b1;
        tick();
        DOUT_OE = 1'b0;
        chk("idle_oe_outcnt", OUT_CNT, 32'd4);
        chk("idle_busy", BUSY, 1'b0);

        // invalid config: CNV_X > ORG_X
        start_cfg(16'd4, 16'd4, 16'd5, 16'd4);
        chk("inv_done", DONE, 1'b1);
        chk("inv_err", ERR, 1'b1);
        chk("inv_busy", BUSY, 1'b0);
        chk("inv_shadow", CNV_X, 16'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("inv_busy_after", BUSY, 1'b0);
            chk("inv_fsync", DIN_FSYNC, 1'b0);
            chk("inv_done_once", DONE, 1'b0);
        end

        // drain timeout: only 3 of 4 outputs
        start_cfg(16'd4, 16'd4, 16'd2, 16'd2);
        chk("to_err_cleared", ERR, 1'b0);
        tick();
        feed(16, 0);
        core_out(3, 1'b0);
        n = 101;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (DONE) begin
                n = i;
                break;
            end
        end
        chk("to_latency", n, 64);
        chk("to_err", ERR, 1'b1);
        chk("to_outcnt", OUT_CNT, 32'd3);
        tick();

        // abort mid-RUN after 7 beats
        start_cfg(16'd4, 16'd4, 16'd2, 16'd2);
        tick();
        feed(7, 0);
        S_VALID = 1'b1;
        S_DATA  = pix(7);
        CFG_ABORT = 1'b1;
        tick();
        CFG_ABORT = 1'b0;
        S_VALID = 1'b0;
        chk("abort_ready", S_READY, 1'b0);
        chk("abort_we", DIN_WE, 1'b0);
        chk("abort_done", DONE, 1'b1);
        chk("abort_err", ERR, 1'b1);
        tick();
        chk("abort_done_once", DONE, 1'b0);
        chk("abort_busy", BUSY, 1'b0);
        start_cfg(16'd4, 16'd4, 16'd2, 16'd2);
        chk("restart_err", ERR, 1'b0);
        tick();
        feed(16, 200);
        core_out(4, 1'b1);
        chk("clean_done", DONE, 1'b1);
        chk("clean_err", ERR, 1'b0);
        chk("clean_outcnt", OUT_CNT, 32'd4);
        tick();

        // START during DRAIN is ignored
        start_cfg(16'd4, 16'd4, 16'd2, 16'd2);
        tick();
        feed(16, 0);
        start_cfg(16'd8, 16'd8, 16'd4, 16'd4);
        chk("drain_start_busy", BUSY, 1'b1);
        chk("drain_start_orgx", ORG_X, 16'd4);
        chk("drain_start_fsync", DIN_FSYNC, 1'b0);
        tick();
        chk("drain_start_fsync2", DIN_FSYNC, 1'b0);
        core_out(4, 1'b1);
        chk("drain_start_done", DONE, 1'b1);
        chk("drain_start_err", ERR, 1'b0);
        tick();

        // RST during RUN
        start_cfg(16'd4, 16'd4, 16'd2, 16'd2);
        tick();
        feed(5, 0);
        DOUT_OE = 1'b1;
        tick();
        DOUT_OE = 1'b0;
        chk("run_oe_counted", OUT_CNT, 32'd1);
        S_VALID = 1'b1;
        RST = 1'b1;
        tick();
        chk("mrst_busy", BUSY, 1'b0);
        chk("mrst_ready", S_READY, 1'b0);
        chk("mrst_we", DIN_WE, 1'b0);
        chk("mrst_din", DIN, 32'h0);
        chk("mrst_orgx", ORG_X, 16'h0);
        chk("mrst_outcnt", OUT_CNT, 32'h0);
        chk("mrst_done", DONE, 1'b0);
        chk("mrst_err", ERR, 1'b0);
        RST = 1'b0;
        S_VALID = 1'b0;
        tick();
        chk("mrst_no_done", DONE, 1'b0);
        chk("mrst_idle", BUSY, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
